// File: rtl/dag_circ.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dag_circ: dual data address generator (DM + PS) with circular addressing,  |
// | pre/post-modify, write-through bypass and bus-connect register read port.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dag_circ #(
  parameter int AW   = 16,
  parameter int NREG = 8,
  parameter int IW   = $clog2(NREG),
  parameter int RAW  = IW + 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps_dg_en,
  input  logic           ps_dg_dgsclt,
  input  logic           ps_dg_mdfy,
  input  logic [IW-1:0]  ps_dg_iadd,
  input  logic [IW-1:0]  ps_dg_madd,
  input  logic           ps_dg_wrt_en,
  input  logic [RAW-1:0] ps_dg_wrt_add,
  input  logic [RAW-1:0] ps_dg_rd_add,
  input  logic [AW-1:0]  bc_dt,
  output logic [AW-1:0]  dg_dm_add,
  output logic           dg_dm_vld,
  output logic [AW-1:0]  dg_ps_add,
  output logic           dg_ps_vld,
  output logic [AW-1:0]  dg_bc_dt
);

  localparam int         NR2    = 2 * NREG;
  localparam logic [1:0] TYPE_I = 2'b00;
  localparam logic [1:0] TYPE_M = 2'b01;
  localparam logic [1:0] TYPE_L = 2'b10;
  localparam logic [1:0] TYPE_B = 2'b11;

  // Register files indexed by {dag, sel}
  logic [AW-1:0] idx_reg  [NR2];
  logic [AW-1:0] mod_reg  [NR2];
  logic [AW-1:0] len_reg  [NR2];
  logic [AW-1:0] base_reg [NR2];

  logic [IW:0]   op_i_idx, op_m_idx, wr_idx, rd_idx;
  logic [1:0]    wr_type, rd_type;
  logic          hit_i, hit_m, hit_l, hit_b;
  logic [AW-1:0] op_i, op_m, op_l, op_b;
  logic [AW-1:0] wrap_val, addr, rd_val;
  logic signed [AW+1:0] t_sum, t_lim, t_base;

  assign op_i_idx = {ps_dg_dgsclt, ps_dg_iadd};
  assign op_m_idx = {ps_dg_dgsclt, ps_dg_madd};
  assign wr_type  = ps_dg_wrt_add[RAW-1:RAW-2];
  assign wr_idx   = ps_dg_wrt_add[IW:0];
  assign rd_type  = ps_dg_rd_add[RAW-1:RAW-2];
  assign rd_idx   = ps_dg_rd_add[IW:0];

  // A B write also loads the paired I, so it bypasses the I operand too
  assign hit_i = ps_dg_wrt_en && (wr_type == TYPE_I || wr_type == TYPE_B) && (wr_idx == op_i_idx);
  assign hit_m = ps_dg_wrt_en && (wr_type == TYPE_M) && (wr_idx == op_m_idx);
  assign hit_l = ps_dg_wrt_en && (wr_type == TYPE_L) && (wr_idx == op_i_idx);
  assign hit_b = ps_dg_wrt_en && (wr_type == TYPE_B) && (wr_idx == op_i_idx);

  assign op_i = hit_i ? bc_dt : idx_reg[op_i_idx];
  assign op_m = hit_m ? bc_dt : mod_reg[op_m_idx];
  assign op_l = hit_l ? bc_dt : len_reg[op_i_idx];
  assign op_b = hit_b ? bc_dt : base_reg[op_i_idx];

  // Extra headroom bit lets an underflowing I+M compare below B as negative
  assign t_sum  = $signed({2'b00, op_i}) + $signed({{2{op_m[AW-1]}}, op_m});
  assign t_lim  = $signed({2'b00, op_b}) + $signed({2'b00, op_l});
  assign t_base = $signed({2'b00, op_b});

  always_comb begin
    wrap_val = t_sum[AW-1:0];
    if (op_l != '0) begin
      if (!op_m[AW-1] && (t_sum >= t_lim)) begin
        wrap_val = t_sum[AW-1:0] - op_l;
      end else if (op_m[AW-1] && (t_sum < t_base)) begin
        wrap_val = t_sum[AW-1:0] + op_l;
      end
    end
  end

  assign addr = ps_dg_mdfy ? wrap_val : op_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NR2; k++) begin
        idx_reg[k]  <= '0;
        mod_reg[k]  <= '0;
        len_reg[k]  <= '0;
        base_reg[k] <= '0;
      end
      dg_dm_add <= '0;
      dg_ps_add <= '0;
      dg_dm_vld <= 1'b0;
      dg_ps_vld <= 1'b0;
    end else begin
      dg_dm_vld <= 1'b0;
      dg_ps_vld <= 1'b0;
      if (ps_dg_wrt_en) begin
        case (wr_type)
          TYPE_I: idx_reg[wr_idx] <= bc_dt;
          TYPE_M: mod_reg[wr_idx] <= bc_dt;
          TYPE_L: len_reg[wr_idx] <= bc_dt;
          default: begin
            base_reg[wr_idx] <= bc_dt;
            idx_reg[wr_idx]  <= bc_dt;
          end
        endcase
      end
      if (ps_dg_en) begin
        // Issued after the write so the post-modify update wins on conflict
        if (!ps_dg_mdfy) begin
          idx_reg[op_i_idx] <= wrap_val;
        end
        if (ps_dg_dgsclt) begin
          dg_ps_add <= addr;
          dg_ps_vld <= 1'b1;
        end else begin
          dg_dm_add <= addr;
          dg_dm_vld <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (rd_type)
      TYPE_I:  rd_val = idx_reg[rd_idx];
      TYPE_M:  rd_val = mod_reg[rd_idx];
      TYPE_L:  rd_val = len_reg[rd_idx];
      default: rd_val = base_reg[rd_idx];
    endcase
  end

  assign dg_bc_dt = (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add)) ? bc_dt : rd_val;

endmodule
`default_nettype wire

// File: tb/tb_dag_circ.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dag_circ: directed self-checking bench for dag_circ.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dag_circ;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy;
  logic [2:0]  ps_dg_iadd, ps_dg_madd;
  logic        ps_dg_wrt_en;
  logic [5:0]  ps_dg_wrt_add, ps_dg_rd_add;
  logic [15:0] bc_dt;
  logic [15:0] dg_dm_add, dg_ps_add, dg_bc_dt;
  logic        dg_dm_vld, dg_ps_vld;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] TI = 2'b00, TM = 2'b01, TL = 2'b10, TB = 2'b11;

  dag_circ #(.AW(16), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .ps_dg_en(ps_dg_en), .ps_dg_dgsclt(ps_dg_dgsclt), .ps_dg_mdfy(ps_dg_mdfy),
    .ps_dg_iadd(ps_dg_iadd), .ps_dg_madd(ps_dg_madd),
    .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_wrt_add(ps_dg_wrt_add),
    .ps_dg_rd_add(ps_dg_rd_add), .bc_dt(bc_dt),
    .dg_dm_add(dg_dm_add), .dg_dm_vld(dg_dm_vld),
    .dg_ps_add(dg_ps_add), .dg_ps_vld(dg_ps_vld),
    .dg_bc_dt(dg_bc_dt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ra(input logic [1:0] ty, input logic dg, input logic [2:0] sl);
    return {ty, dg, sl};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = a; bc_dt = d;
    cycle();
    ps_dg_wrt_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [15:0] v);
    ps_dg_rd_add = a;
    #1;
    v = dg_bc_dt;
  endtask

  task automatic set_acc(input logic dg, input logic mdfy, input logic [2:0] ia, input logic [2:0] ma);
    ps_dg_en = 1'b1; ps_dg_dgsclt = dg; ps_dg_mdfy = mdfy; ps_dg_iadd = ia; ps_dg_madd = ma;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    for (int t = 0; t < 4; t++)
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < 8; s++)
          wr(ra(2'(t), 1'(d), 3'(s)), 16'h1000 + 16'(t * 16 + d * 8 + s + 1));
    set_acc(1'b0, 1'b1, 3'd1, 3'd2); cycle();
    set_acc(1'b1, 1'b1, 3'd3, 3'd4); cycle();
    ps_dg_en = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    checks++; if (dg_dm_add !== 16'h0) begin errors++; $display("FAIL reset_dm_add got %h exp 0000", dg_dm_add); end
    checks++; if (dg_ps_add !== 16'h0) begin errors++; $display("FAIL reset_ps_add got %h exp 0000", dg_ps_add); end
    checks++; if (dg_dm_vld !== 1'b0 || dg_ps_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b%b exp 00", dg_dm_vld, dg_ps_vld); end
    for (int t = 0; t < 4; t++)
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < 8; s++) begin
          rd(ra(2'(t), 1'(d), 3'(s)), v);
          checks++;
          if (v !== 16'h0) begin errors++; $display("FAIL reset_reg t%0d d%0d s%0d got %h exp 0000", t, d, s, v); end
        end
  endtask

  task automatic test_linear();
    logic [15:0] v;
    wr(ra(TI, 1'b0, 3'd0), 16'h0040);
    wr(ra(TM, 1'b0, 3'd0), 16'h0004);
    set_acc(1'b0, 1'b0, 3'd0, 3'd0);
    cycle();
    checks++; if (dg_dm_add !== 16'h0040 || dg_dm_vld !== 1'b1) begin errors++; $display("FAIL lin_1 got %h/%b exp 0040/1", dg_dm_add, dg_dm_vld); end
    cycle();
    checks++; if (dg_dm_add !== 16'h0044 || dg_dm_vld !== 1'b1) begin errors++; $display("FAIL lin_2 got %h/%b exp 0044/1", dg_dm_add, dg_dm_vld); end
    cycle();
    checks++; if (dg_dm_add !== 16'h0048 || dg_dm_vld !== 1'b1 || dg_ps_vld !== 1'b0) begin errors++; $display("FAIL lin_3 got %h/%b/%b exp 0048/1/0", dg_dm_add, dg_dm_vld, dg_ps_vld); end
    ps_dg_en = 1'b0;
    cycle();
    checks++; if (dg_dm_add !== 16'h0048 || dg_dm_vld !== 1'b0) begin errors++; $display("FAIL lin_hold got %h/%b exp 0048/0", dg_dm_add, dg_dm_vld); end
    rd(ra(TI, 1'b0, 3'd0), v);
    checks++; if (v !== 16'h004C) begin errors++; $display("FAIL lin_i0 got %h exp 004c", v); end
  endtask

  task automatic test_circular();
    logic [15:0] v;
    wr(ra(TB, 1'b1, 3'd1), 16'h0100);
    rd(ra(TI, 1'b1, 3'd1), v);
    checks++; if (v !== 16'h0100) begin errors++; $display("FAIL circ_b_loads_i got %h exp 0100", v); end
    wr(ra(TL, 1'b1, 3'd1), 16'h0010);
    wr(ra(TI, 1'b1, 3'd1), 16'h010E);
    wr(ra(TM, 1'b1, 3'd1), 16'h0003);
    set_acc(1'b1, 1'b0, 3'd1, 3'd1); cycle(); ps_dg_en = 1'b0;
    checks++; if (dg_ps_add !== 16'h010E || dg_ps_vld !== 1'b1 || dg_dm_vld !== 1'b0) begin errors++; $display("FAIL circ_post got %h/%b/%b exp 010e/1/0", dg_ps_add, dg_ps_vld, dg_dm_vld); end
    checks++; if (dg_dm_add !== 16'h0048) begin errors++; $display("FAIL circ_dm_hold got %h exp 0048", dg_dm_add); end
    rd(ra(TI, 1'b1, 3'd1), v);
    checks++; if (v !== 16'h0101) begin errors++; $display("FAIL circ_post_i got %h exp 0101", v); end
    wr(ra(TI, 1'b1, 3'd1), 16'h010E);
    set_acc(1'b1, 1'b1, 3'd1, 3'd1); cycle(); ps_dg_en = 1'b0;
    checks++; if (dg_ps_add !== 16'h0101 || dg_ps_vld !== 1'b1) begin errors++; $display("FAIL circ_pre got %h/%b exp 0101/1", dg_ps_add, dg_ps_vld); end
    rd(ra(TI, 1'b1, 3'd1), v);
    checks++; if (v !== 16'h010E) begin errors++; $display("FAIL circ_pre_i got %h exp 010e", v); end
    cycle();
    checks++; if (dg_ps_add !== 16'h0101 || dg_ps_vld !== 1'b0) begin errors++; $display("FAIL circ_idle got %h/%b exp 0101/0", dg_ps_add, dg_ps_vld); end
  endtask

  task automatic test_backward();
    logic [15:0] v;
    wr(ra(TI, 1'b1, 3'd1), 16'h0101);
    wr(ra(TM, 1'b1, 3'd1), 16'hFFFD);
    set_acc(1'b1, 1'b0, 3'd1, 3'd1); cycle(); ps_dg_en = 1'b0;
    checks++; if (dg_ps_add !== 16'h0101) begin errors++; $display("FAIL back_addr got %h exp 0101", dg_ps_add); end
    rd(ra(TI, 1'b1, 3'd1), v);
    checks++; if (v !== 16'h010E) begin errors++; $display("FAIL back_i got %h exp 010e", v); end
  endtask

  task automatic test_bypass();
    logic [15:0] v;
    wr(ra(TI, 1'b0, 3'd2), 16'h0010);
    wr(ra(TM, 1'b0, 3'd2), 16'h0002);
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = ra(TI, 1'b0, 3'd2); bc_dt = 16'h0200;
    set_acc(1'b0, 1'b0, 3'd2, 3'd2);
    rd(ra(TI, 1'b0, 3'd2), v);
    checks++; if (v !== 16'h0200) begin errors++; $display("FAIL byp_read got %h exp 0200", v); end
    cycle(); ps_dg_en = 1'b0; ps_dg_wrt_en = 1'b0;
    checks++; if (dg_dm_add !== 16'h0200 || dg_dm_vld !== 1'b1) begin errors++; $display("FAIL byp_addr got %h/%b exp 0200/1", dg_dm_add, dg_dm_vld); end
    rd(ra(TI, 1'b0, 3'd2), v);
    checks++; if (v !== 16'h0202) begin errors++; $display("FAIL byp_i got %h exp 0202", v); end
    // M written in the same cycle as a pre-modify that uses it
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = ra(TM, 1'b0, 3'd2); bc_dt = 16'h0005;
    set_acc(1'b0, 1'b1, 3'd2, 3'd2); cycle(); ps_dg_en = 1'b0; ps_dg_wrt_en = 1'b0;
    checks++; if (dg_dm_add !== 16'h0207) begin errors++; $display("FAIL byp_m_addr got %h exp 0207", dg_dm_add); end
    rd(ra(TM, 1'b0, 3'd2), v);
    checks++; if (v !== 16'h0005) begin errors++; $display("FAIL byp_m_reg got %h exp 0005", v); end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] v;
    rst = 1'b1;
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = ra(TI, 1'b0, 3'd3); bc_dt = 16'h0055;
    set_acc(1'b0, 1'b0, 3'd0, 3'd0);
    cycle();
    rst = 1'b0; ps_dg_en = 1'b0; ps_dg_wrt_en = 1'b0;
    checks++; if (dg_dm_vld !== 1'b0 || dg_dm_add !== 16'h0) begin errors++; $display("FAIL mid_rst_out got %h/%b exp 0000/0", dg_dm_add, dg_dm_vld); end
    rd(ra(TI, 1'b0, 3'd0), v);
    checks++; if (v !== 16'h0) begin errors++; $display("FAIL mid_rst_i0 got %h exp 0000", v); end
    rd(ra(TI, 1'b0, 3'd3), v);
    checks++; if (v !== 16'h0) begin errors++; $display("FAIL mid_rst_i3 got %h exp 0000", v); end
  endtask

  initial begin
    rst = 1'b1; ps_dg_en = 1'b0; ps_dg_dgsclt = 1'b0; ps_dg_mdfy = 1'b0;
    ps_dg_iadd = '0; ps_dg_madd = '0; ps_dg_wrt_en = 1'b0;
    ps_dg_wrt_add = '0; ps_dg_rd_add = '0; bc_dt = '0;
    cycle(); cycle();
    rst = 1'b0;
    test_reset();
    test_linear();
    test_circular();
    test_backward();
    test_bypass();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
